// File: rtl/fetch_if.sv
// fetch_if: signal bundle between fetch_queue, instruction memory, redirect source and decode
// master: fetch_queue side (drives imem_req/imem_line, inst/inst_pc/inst_valid, fault)
// slave: environment side (drives imem_data, redirect/redirect_addr, inst_ready)
interface fetch_if #(
  parameter int LINE_W = 12
);
  logic              imem_req;
  logic [LINE_W-1:0] imem_line;
  logic [31:0]       imem_data;
  logic              redirect;
  logic [31:0]       redirect_addr;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              fault;
  modport master (
    output imem_req, imem_line, inst, inst_pc, inst_valid, fault,
    input  imem_data, redirect, redirect_addr, inst_ready
  );
  modport slave (
    input  imem_req, imem_line, inst, inst_pc, inst_valid, fault,
    output imem_data, redirect, redirect_addr, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage buffering PC-tagged words for decode
// Ports: clk, rst (sync, active-high); bus (fetch_if.master):
//   imem_req/imem_line out, imem_data in (1-cycle read latency),
//   redirect/redirect_addr in, inst/inst_pc/inst_valid out, inst_ready in, fault out (sticky).
// Build option: define FETCH_BYPASS_EN to present a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          LINE_W   = 12
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH);
  logic [31:0]   fetch_pc, req_pc;
  logic          inflight;
  logic [CW-1:0] rd_ptr, wr_ptr;
  logic [CW:0]   count;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc [DEPTH];
  logic          empty, resp, wr, pop;
  assign empty = count == '0;
  // a redirect kills the response arriving in the same cycle
  assign resp  = inflight && !bus.redirect;
  // the in-flight word already owns a slot, so it counts against capacity
  assign bus.imem_req  = !rst && !bus.fault && !bus.redirect &&
                         (count + (CW+1)'(inflight)) < (CW+1)'(DEPTH);
  assign bus.imem_line = fetch_pc[LINE_W+1:2];
  assign pop           = !empty && bus.inst_ready;
`ifdef FETCH_BYPASS_EN
  assign bus.inst_valid = !empty || resp;
  assign bus.inst       = !empty ? mem_inst[rd_ptr] : resp ? bus.imem_data : '0;
  assign bus.inst_pc    = !empty ? mem_pc[rd_ptr] : resp ? req_pc : '0;
  assign wr             = resp && !(empty && bus.inst_ready);
`else
  assign bus.inst_valid = !empty;
  assign bus.inst       = empty ? '0 : mem_inst[rd_ptr];
  assign bus.inst_pc    = empty ? '0 : mem_pc[rd_ptr];
  assign wr             = resp;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      inflight  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      bus.fault <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc  <= bus.redirect_addr;
      inflight  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      bus.fault <= bus.fault || (bus.redirect_addr[1:0] != 2'b00);
    end else begin
      if (bus.imem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      inflight <= bus.imem_req;
      if (wr) wr_ptr <= wr_ptr + CW'(1);
      if (pop) rd_ptr <= rd_ptr + CW'(1);
      count <= count + (CW+1)'(wr) - (CW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_inst[wr_ptr] <= bus.imem_data;
      mem_pc[wr_ptr]   <= req_pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue
module tb_fetch_queue;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int failed = 0;
  int n;
  logic any;
  logic [31:0] exp_pc;
  fetch_if #(.LINE_W(12)) bus ();
  fetch_queue #(.RESET_PC(32'h0), .DEPTH(4), .LINE_W(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.imem_req) bus.imem_data <= 32'h1000_0000 + 32'(bus.imem_line);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
    check({tag, "_pc"}, bus.inst_pc, pc);
    check({tag, "_inst"}, bus.inst, 32'h1000_0000 + {20'b0, pc[13:2]});
  endtask
  initial begin
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_addr = '0;
    bus.inst_ready = 1'b1;
    cyc();
    cyc();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_pc", bus.inst_pc, 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    // streaming from RESET_PC with decode always ready
    rst = 1'b0;
    #1;
    check("rel_req", 32'(bus.imem_req), 32'd1);
    check("rel_line", 32'(bus.imem_line), 32'd0);
    for (int k = 0; k < LAT; k++) begin
      check("fill_valid", 32'(bus.inst_valid), 32'd0);
      cyc();
    end
    for (int k = 0; k < 6; k++) begin
      check_head("stream", 32'(4 * k));
      cyc();
    end
    // backpressure: decode stalled for 10 cycles after release
    rst = 1'b1;
    bus.inst_ready = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req) n++;
      if (i == LAT + 1) check_head("stall_mid", 32'd0);
      cyc();
    end
    check("stall_issues", 32'(n), 32'd4);
    check("stall_req", 32'(bus.imem_req), 32'd0);
    check_head("stall_end", 32'd0);
    bus.inst_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_head("drain", 32'(4 * k));
      cyc();
    end
    // redirect with three words buffered and one in flight
    rst = 1'b1;
    bus.inst_ready = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    bus.redirect = 1'b1;
    bus.redirect_addr = 32'h40;
    #1;
    check("redir_noreq", 32'(bus.imem_req), 32'd0);
    cyc();
    bus.redirect = 1'b0;
    bus.inst_ready = 1'b1;
    #1;
    check("redir_flush", 32'(bus.inst_valid), 32'd0);
    check("redir_line", 32'(bus.imem_line), 32'h10);
    exp_pc = 32'h40;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.inst_valid) begin
        check_head("redir_seq", exp_pc);
        exp_pc += 32'd4;
        n++;
      end
      cyc();
    end
    check("redir_count", 32'(n), 32'(8 - LAT));
    // misaligned redirect: sticky fault until reset
    bus.redirect = 1'b1;
    bus.redirect_addr = 32'h42;
    cyc();
    bus.redirect = 1'b0;
    #1;
    check("fault_set", 32'(bus.fault), 32'd1);
    check("fault_req", 32'(bus.imem_req), 32'd0);
    check("fault_valid", 32'(bus.inst_valid), 32'd0);
    any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      any |= bus.imem_req | bus.inst_valid;
      cyc();
    end
    check("fault_quiet", 32'(any), 32'd0);
    rst = 1'b1;
    cyc();
    check("fault_clear", 32'(bus.fault), 32'd0);
    rst = 1'b0;
    #1;
    check("fault_restart_line", 32'(bus.imem_line), 32'd0);
    check("fault_restart_req", 32'(bus.imem_req), 32'd1);
    for (int k = 0; k < LAT; k++) cyc();
    check_head("fault_restart", 32'd0);
    // wrap of fetch_pc and the memory line
    bus.redirect = 1'b1;
    bus.redirect_addr = 32'hFFFF_FFFC;
    cyc();
    bus.redirect = 1'b0;
    #1;
    check("wrap_line_hi", 32'(bus.imem_line), 32'hFFF);
    check("wrap_valid0", 32'(bus.inst_valid), 32'd0);
    cyc();
    check("wrap_line_lo", 32'(bus.imem_line), 32'd0);
    for (int k = 0; k < LAT - 1; k++) cyc();
    check_head("wrap_top", 32'hFFFF_FFFC);
    cyc();
    check_head("wrap_zero", 32'h0);
    // redirect with a handshake and a response in the same cycle
    bus.redirect = 1'b1;
    bus.redirect_addr = 32'h100;
    cyc();
    bus.redirect = 1'b0;
    #1;
    check("kill_empty", 32'(bus.inst_valid), 32'd0);
    for (int k = 0; k < LAT - 1; k++) begin
      cyc();
      check("kill_empty2", 32'(bus.inst_valid), 32'd0);
    end
    cyc();
    check_head("kill_first", 32'h100);
    cyc();
    check_head("kill_next", 32'h104);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of decode_unit.
- Owns the fetch PC and drives the instruction port of memory with a registered 1-cycle read.
- Buffers returned words, each tagged with its PC, in a small FIFO.
- Presents them to decode through a valid/ready handshake; a redirect flushes the FIFO and restarts fetch at a new address.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DEPTH, 4, FIFO entries (power of two, at least 2).
- LINE_W, 12, width of the memory line index; the line is fetch_pc[LINE_W+1:2].

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request issued this cycle.
- imem_line  out  LINE_W  word line to read; valid when imem_req=1.
- imem_data  in  32  read data, valid the cycle after imem_req.
- redirect  in  1  flush and restart fetch (taken jump/branch).
- redirect_addr  in  32  new fetch address.
- inst  out  32  instruction at FIFO head.
- inst_pc  out  32  PC of inst.
- inst_valid  out  1  head entry valid.
- inst_ready  in  1  decode accepts head.
- fault  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC; FIFO empty; in-flight flag clear; fault=0.
  - Outputs: inst_valid=0, imem_req=0, inst=0, inst_pc=0.
  - rst overrides every other input; reset mid-stream discards all entries and the in-flight response.
- Issue:
  - imem_req=1 iff !rst, !fault, !redirect, and count + inflight < DEPTH.
  - On issue: imem_line=fetch_pc[LINE_W+1:2]; the PC is latched as req_pc; inflight<=1; fetch_pc<=fetch_pc+4.
  - fetch_pc addition wraps modulo 2^32.
  - At most one request per cycle.
- Response:
  - The cycle after an issue, imem_data with req_pc is written to the FIFO tail, unless killed.
  - inflight clears unless a new request is issued that cycle.
  - Back-to-back issue gives 1 word/cycle steady-state throughput.
- Output:
  - inst/inst_pc/inst_valid come from the FIFO head.
  - A transfer occurs when inst_valid and inst_ready are both 1 at posedge.
  - While inst_valid=1 and inst_ready=0, inst and inst_pc hold stable.
- Full/empty:
  - Simultaneous write and pop when full is legal; count is unchanged.
  - A pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
- Redirect (redirect=1 at posedge):
  - FIFO cleared; any in-flight response marked killed and dropped the next cycle.
  - fetch_pc<=redirect_addr; no issue in the redirect cycle.
  - Redirect wins over a simultaneous handshake, response, or issue.
  - A handshake in the same cycle still counts as consumed by decode.
- Latency: redirect at cycle N gives imem_req for the target at N+1, data at N+2, and inst_valid at N+3 (see the optional feature).
- Fault:
  - redirect with redirect_addr[1:0]!=0 sets fault=1 and flushes as a normal redirect.
  - fetch_pc is still loaded.
  - Issue is then inhibited until rst; inst_valid stays 0.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a non-killed response arrives, the outputs present imem_data/req_pc combinationally with inst_valid=1.
  - If inst_ready=1 the word is consumed without a FIFO write; otherwise it is written to the FIFO.
  - Redirect-to-valid latency becomes N+2.
- Undefined: all responses go through the FIFO, giving redirect-to-valid N+3 and reset-release-to-first-valid 3 cycles.
- Bypass is suppressed in a redirect cycle.

Test Plan:
- Reset release, RESET_PC=0, inst_ready=1, memory word k = 32'h1000_0000+k → inst_pc sequence 0,4,8,C… with inst matching; one transfer per cycle after fill.
- inst_ready=0 for 10 cycles after release → imem_req stops once 4 entries are buffered; inst/inst_pc frozen at 32'h1000_0000/0; no entry lost or duplicated when ready returns.
- redirect with redirect_addr=32'h40 while 3 entries are buffered and one is in flight → inst_valid=0 next cycle; first delivered inst_pc=32'h40 with word 16's data; no stale PC 0xC/0x10 ever appears.
- redirect_addr=32'h42 → fault=1 next cycle, imem_req=0 and inst_valid=0 forever; rst for 1 cycle clears fault and fetch restarts at RESET_PC.
- redirect_addr=32'hFFFF_FFFC → inst_pc sequence FFFF_FFFC then 0000_0000; imem_line wraps to 0.
- Redirect and inst_ready=1 asserted in the same cycle as a memory response → response dropped, FIFO empty next cycle, count never negative; in FETCH_BYPASS_EN build, latency check: redirect at N gives inst_valid at N+2.
